// File: rtl/pe_pkg.sv
// ---------------------------------------------------------------------------
// pe_pkg : shared constants, index type and log2 helper for the priority
//          encoder.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pe_pkg;

  localparam int PE_WIDTH = 4;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r++;
    end
    return r;
  endfunction

  localparam int PE_OUT_W = clog2(PE_WIDTH);

  typedef logic [PE_OUT_W-1:0] pe_idx_t;

endpackage : pe_pkg

`default_nettype wire

// File: rtl/pe_core.sv
// ---------------------------------------------------------------------------
// pe_core : combinational priority encoder, highest asserted index wins.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pe_core
  import pe_pkg::*;
#(
  parameter int WIDTH = PE_WIDTH
) (
  input  logic [WIDTH-1:0]        i,
  output logic [clog2(WIDTH)-1:0] y_n,
  output logic                    v_n
);

  localparam int OUT_W = clog2(WIDTH);

  // Ascending scan so later (higher) indices override; the ternary keeps an
  // X request visible on the index instead of silently treating it as 0.
  always_comb begin
    y_n = '0;
    v_n = |i;
    for (int k = 0; k < WIDTH; k++) begin
      y_n = i[k] ? OUT_W'(k) : y_n;
    end
  end

endmodule : pe_core

`default_nettype wire

// File: rtl/priority_encoder_4x2.sv
// ---------------------------------------------------------------------------
// priority_encoder_4x2 : registered priority encoder, 1-cycle latency,
//                        asynchronous active-high reset.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module priority_encoder_4x2
  import pe_pkg::*;
#(
  parameter int WIDTH = PE_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        i,
  output logic [clog2(WIDTH)-1:0] y,
  output logic                    v
);

  localparam int OUT_W = clog2(WIDTH);

  logic [OUT_W-1:0] y_d;
  logic             v_d;
  logic [OUT_W-1:0] y_q;
  logic             v_q;

  pe_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .i   (i),
    .y_n (y_d),
    .v_n (v_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q <= '0;
      v_q <= 1'b0;
    end else begin
      y_q <= y_d;
      v_q <= v_d;
    end
  end

  assign y = y_q;
  assign v = v_q;

endmodule : priority_encoder_4x2

`default_nettype wire

// File: tb/tb_priority_encoder_4x2.sv
// ---------------------------------------------------------------------------
// tb_priority_encoder_4x2 : scoreboard bench for the registered encoder.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_priority_encoder_4x2;
  import pe_pkg::*;

  typedef struct {
    pe_idx_t y;
    logic    v;
    int      id;
  } exp_t;

  logic          clk;
  logic          rst;
  logic [3:0]    i;
  pe_idx_t       y;
  logic          v;

  exp_t          sb_q[$];
  int            checks;
  int            errors;
  int            tag;

  priority_encoder_4x2 #(
    .WIDTH (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .i   (i),
    .y   (y),
    .v   (v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every edge presents a new result; pop and compare when one is owed.
  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      checks++;
      if (y !== e.y || v !== e.v) begin
        errors++;
        $display("FAIL sb#%0d: got y=%0d v=%0b, expected y=%0d v=%0b",
                 e.id, y, v, e.y, e.v);
      end
    end
  end

  task automatic direct_check(input string name, input pe_idx_t ey, input logic ev);
    checks++;
    if (y !== ey || v !== ev) begin
      errors++;
      $display("FAIL %s: got y=%0d v=%0b, expected y=%0d v=%0b", name, y, v, ey, ev);
    end
  endtask

  // Drive one request vector and queue the result due after the next edge.
  task automatic apply(input logic [3:0] val, input pe_idx_t ey, input logic ev);
    exp_t e;
    @(negedge clk);
    i    = val;
    e.y  = ey;
    e.v  = ev;
    e.id = tag;
    tag++;
    sb_q.push_back(e);
  endtask

  pe_idx_t sweep_y [16] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2,
                            2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
  logic    sweep_v [16] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                            1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    tag    = 0;
    rst    = 1'b0;
    i      = 4'b1111;

    // Reset takes effect before any clock edge.
    #1 rst = 1'b1;
    #1 direct_check("rst_async", 2'd0, 1'b0);
    @(posedge clk);
    #1 direct_check("rst_held", 2'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    begin
      exp_t e;
      e.y = 2'd3; e.v = 1'b1; e.id = tag; tag++;
      sb_q.push_back(e);
    end

    // Sweep, with an asynchronous reset landing on i=0110.
    for (int k = 0; k < 16; k++) begin
      if (k == 6) begin
        @(negedge clk);
        i = 4'(k);
        #2 rst = 1'b1;
        #1 direct_check("rst_mid_async", 2'd0, 1'b0);
        @(posedge clk);
        #1 direct_check("rst_mid_held", 2'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1 direct_check("rst_mid_release", 2'd0, 1'b0);
        begin
          exp_t e;
          e.y = 2'd2; e.v = 1'b1; e.id = tag; tag++;
          sb_q.push_back(e);
        end
      end else begin
        apply(4'(k), sweep_y[k], sweep_v[k]);
      end
    end

    // Lower bits masked by a higher request.
    apply(4'b0101, 2'd2, 1'b1);
    apply(4'b1010, 2'd3, 1'b1);
    apply(4'b0011, 2'd1, 1'b1);

    // Back-to-back alternation, no bubbles.
    for (int n = 0; n < 4; n++) begin
      apply(4'b0001, 2'd0, 1'b1);
      apply(4'b1000, 2'd3, 1'b1);
    end

    // Zero after activity.
    apply(4'b1000, 2'd3, 1'b1);
    apply(4'b0000, 2'd0, 1'b0);

    begin
      int budget;
      budget = 0;
      while (sb_q.size() > 0 && budget < 5) begin
        @(posedge clk);
        budget++;
      end
      @(negedge clk);
      checks++;
      if (sb_q.size() != 0) begin
        errors++;
        $display("FAIL drain: got %0d pending, expected 0", sb_q.size());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_priority_encoder_4x2

`default_nettype wire

// File: doc/priority_encoder_4x2.md
Name: priority_encoder_4x2

Overview:
- Registered 4-input priority encoder. Reports the index of the highest-priority asserted request bit, plus a valid flag.
- Used wherever a small request vector must be collapsed to a binary index, e.g. interrupt or arbiter front-ends.
- Encoding logic is combinational. Outputs are registered on one clock with an asynchronous active-high reset.

Parameters:
- WIDTH, 4, number of request inputs; must be a power of two and at least 2.
- OUT_W, $clog2(WIDTH) = 2, width of the encoded index output; derived, not overridden.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  reset, asynchronous, active-high.
- i  input  WIDTH (4)  request vector; bit k is request k.
- y  output  OUT_W (2)  encoded index of the highest-priority asserted request.
- v  output  1  valid: high when at least one bit of i was set.

Behaviour:
- Interface is fixed: one clock; reset is asynchronous and active-high (clk, rst).
- Priority: the highest index wins. i[WIDTH-1] has top priority and i[0] the lowest.
- Combinational next-state:
  - v_n = |i.
  - y_n = largest k with i[k] = 1.
  - If i = 0: v_n = 0 and y_n = 0.
- Registered outputs: y and v update on each rising clk edge from y_n and v_n. Latency is exactly 1 cycle from i to outputs.
- No enable or handshake. A new i is accepted every cycle, for full throughput.
- Reset:
  - While rst = 1, y = 0 and v = 0 immediately, without waiting for a clock edge.
  - After deassertion, the first rising edge captures the current i.
- Reset asserted mid-stream discards the in-flight result. Outputs stay 0 until the first edge after release.
- Lower bits are don't-care whenever a higher bit is set, e.g. 4'b1xxx gives y = 3.
- Truth table for WIDTH = 4, values shown one cycle after i is applied:
  - 0000: v=0, y=00
  - 0001: v=1, y=00
  - 001x: v=1, y=01
  - 01xx: v=1, y=10
  - 1xxx: v=1, y=11
- y = 0 with v = 0 (no request) is distinguished from y = 0 with v = 1 (request 0) only by v. Consumers must qualify y with v.
- X on any bit of i must not be masked in simulation. X propagation to outputs is acceptable.

Decomposition:
- Shared package (pe_pkg):
  - WIDTH default constant.
  - A function clog2 if not using the built-in.
  - Typedef for the index type (logic [OUT_W-1:0]).
- Sub-module pe_core:
  - Purely combinational.
  - Parameterised by WIDTH.
  - Produces y_n and v_n with a descending-priority loop or casez.
- priority_encoder_4x2 wraps pe_core and adds the output register stage with asynchronous reset.

Test Plan:
- Reset: rst=1 with i=4'b1111 -> y=00, v=0 asynchronously, before any clk edge. Release rst; after 1 edge -> y=11, v=1.
- Exhaustive sweep: i = 0..15, one value per cycle -> each result appears one cycle later and matches the truth table. Check i=0 -> v=0, y=00; i=1 -> 00; i=2,3 -> 01; i=4..7 -> 10; i=8..15 -> 11, with v=1 for all nonzero i.
- Priority masking: i=4'b0101 -> y=10, v=1. i=4'b1010 -> y=11. i=4'b0011 -> y=01.
- Back-to-back throughput: alternate i=4'b0001 and 4'b1000 every cycle -> y alternates 00 and 11 with 1-cycle lag and no bubbles; v stays 1.
- Mid-stream reset: during the sweep, assert rst asynchronously between edges at i=4'b0110 -> y=00, v=0 immediately; they remain so until the first edge after release.
- Zero after activity: i=4'b1000 then i=4'b0000 -> v falls to 0 and y returns to 00 one cycle later.
